rock_field: RTL and testbench

Parametrised pool of NUM_ROCKS asteroid slots that replaces the single-rock block in the game datapath. Accepts spawn requests through a valid/ready handshake, moves every active rock once per frame with screen wrap-around, shrinks or splits rocks on hit commands, and renders the combined rock layer, with the covering slot index, one clock after each scan coordinate. Sits between the game controller (spawn/hit) and the pixel mixer/collision logic.

---
 rtl/rocks_pkg.sv | 46 ++++
 rtl/rock_slot.sv | 64 ++++++
 rtl/rock_field.sv | 174 +++++++++++++++++
 tb/tb_rock_field.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rocks_pkg.sv
// Shared rock-pool types, default geometry and wrap/clamp helpers.
// Structs use fixed maximum field widths so one definition serves every parameterisation.
package rocks_pkg;
  localparam int COORD_MAX   = 16;
  localparam int MAG_MAX     = 4;
  localparam int DEF_R_LARGE = 12;
  localparam int DEF_R_SMALL = 6;
  localparam int DEF_CUT     = 2;

  typedef enum logic {
    LARGE = 1'b0,
    SMALL = 1'b1
  } rock_size_e;

  typedef struct packed {
    logic               neg;
    logic [MAG_MAX-1:0] mag;
  } vel_t;

  typedef struct packed {
    logic                 active;
    rock_size_e           size;
    logic [COORD_MAX-1:0] x;
    logic [COORD_MAX-1:0] y;
    vel_t                 vx;
    vel_t                 vy;
  } slot_t;

  // One step never exceeds the modulus, so a single add/subtract restores range.
  function automatic logic [COORD_MAX-1:0] wrap_step(input logic [COORD_MAX-1:0] p,
                                                     input vel_t v, input int modulus);
    int n;
    n = int'(p);
    if (v.neg) n = n - int'(v.mag);
    else       n = n + int'(v.mag);
    if (n >= modulus)  n = n - modulus;
    else if (n < 0)    n = n + modulus;
    return COORD_MAX'(n);
  endfunction

  function automatic logic [COORD_MAX-1:0] clamp_coord(input logic [COORD_MAX-1:0] p,
                                                       input int modulus);
    if (int'(p) >= modulus) return COORD_MAX'(modulus - 1);
    return p;
  endfunction
endpackage

// File: rtl/rock_slot.sv
// One rock slot: state register, per-frame wrapped motion, combinational scan coverage.
// ROCK_SPLIT_EN adds the shrink command and exports full slot state for child creation.
module rock_slot import rocks_pkg::*; #(
  parameter int COORD_W  = 10,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int R_LARGE  = DEF_R_LARGE,
  parameter int R_SMALL  = DEF_R_SMALL,
  parameter int CUT      = DEF_CUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  slot_t              i_load_st,
  input  logic               i_free,
  input  logic               i_move,
`ifdef ROCK_SPLIT_EN
  input  logic               i_shrink,
  output slot_t              o_st,
`endif
  input  logic [COORD_W-1:0] i_px,
  input  logic [COORD_W-1:0] i_py,
  output logic               o_active,
  output logic               o_cover
);
  slot_t r_st;
  int    w_dx;
  int    w_dy;
  int    w_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_st <= '0;
    end else if (i_load) begin
      r_st <= i_load_st;
    end else if (i_free) begin
      r_st.active <= 1'b0;
`ifdef ROCK_SPLIT_EN
    end else if (i_shrink) begin
      r_st.size   <= SMALL;
      r_st.vx.neg <= ~r_st.vx.neg;
`endif
    end else if (i_move && r_st.active) begin
      r_st.x <= wrap_step(r_st.x, r_st.vx, SCREEN_W);
      r_st.y <= wrap_step(r_st.y, r_st.vy, SCREEN_H);
    end
  end

  // Plain distance, no wrap: a rock straddling an edge is clipped rather than mirrored.
  always_comb begin
    w_dx = int'(i_px) - int'(r_st.x);
    if (w_dx < 0) w_dx = -w_dx;
    w_dy = int'(i_py) - int'(r_st.y);
    if (w_dy < 0) w_dy = -w_dy;
    w_r = (r_st.size == LARGE) ? R_LARGE : R_SMALL;
    o_cover = r_st.active && (int'(i_px) < SCREEN_W) && (int'(i_py) < SCREEN_H) &&
              (((w_dx < w_r) && (w_dy < w_r - CUT)) || ((w_dx < w_r - CUT) && (w_dy < w_r)));
  end

  assign o_active = r_st.active;
`ifdef ROCK_SPLIT_EN
  assign o_st = r_st;
`endif
endmodule

// File: rtl/rock_field.sv
// Pool of NUM_ROCKS rock slots: spawn handshake, hit arbitration, 1-cycle registered render.
// ROCK_SPLIT_EN: a hit LARGE rock shrinks and spawns a SMALL child; otherwise it is freed.
module rock_field import rocks_pkg::*; #(
  parameter int NUM_ROCKS = 8,
  parameter int COORD_W   = 10,
  parameter int SPEED_W   = 2,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int R_LARGE   = DEF_R_LARGE,
  parameter int R_SMALL   = DEF_R_SMALL,
  parameter int CUT       = DEF_CUT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_tick,
  input  logic                         spawn_valid,
  output logic                         spawn_ready,
  input  logic [COORD_W-1:0]           spawn_x,
  input  logic [COORD_W-1:0]           spawn_y,
  input  logic [SPEED_W:0]             spawn_vx,
  input  logic [SPEED_W:0]             spawn_vy,
  input  logic                         hit_valid,
  input  logic [$clog2(NUM_ROCKS)-1:0] hit_slot,
  input  logic [COORD_W-1:0]           px,
  input  logic [COORD_W-1:0]           py,
  output logic                         pixel,
  output logic [$clog2(NUM_ROCKS)-1:0] pixel_slot,
  output logic [NUM_ROCKS-1:0]         active_mask,
  output logic [$clog2(NUM_ROCKS):0]   active_count
);
  localparam int SW = $clog2(NUM_ROCKS);
  localparam int CW = SW + 1;

  logic [NUM_ROCKS-1:0] w_cover;
  logic [NUM_ROCKS-1:0] w_load;
  logic [NUM_ROCKS-1:0] w_free;
  logic [NUM_ROCKS-1:0] w_move;
  logic [NUM_ROCKS-1:0] w_hit_sel;
  logic                 w_free_any;
  logic [SW-1:0]        w_free_idx;
  logic                 w_spawn_fire;
  logic                 w_child_vld;
  slot_t                w_spawn_st;
  slot_t                w_child_st;
  slot_t                w_load_st;
  logic                 w_pix_any;
  logic [SW-1:0]        w_pix_idx;
  logic                 r_pixel;
  logic [SW-1:0]        r_pixel_slot;

  always_comb begin
    for (int i = 0; i < NUM_ROCKS; i++) begin
      w_hit_sel[i] = hit_valid && (hit_slot == SW'(i)) && active_mask[i];
    end
  end

  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_ROCKS - 1; i >= 0; i--) begin
      if (!active_mask[i]) begin
        w_free_any = 1'b1;
        w_free_idx = SW'(i);
      end
    end
  end

  // Any hit command, even on an idle slot, owns the cycle and stalls spawn.
  assign spawn_ready  = w_free_any && !hit_valid;
  assign w_spawn_fire = spawn_valid && spawn_ready;

  always_comb begin
    w_spawn_st        = '0;
    w_spawn_st.active = 1'b1;
    w_spawn_st.size   = LARGE;
    w_spawn_st.x      = clamp_coord(COORD_MAX'(spawn_x), SCREEN_W);
    w_spawn_st.y      = clamp_coord(COORD_MAX'(spawn_y), SCREEN_H);
    w_spawn_st.vx.neg = spawn_vx[SPEED_W];
    w_spawn_st.vx.mag = MAG_MAX'(spawn_vx[SPEED_W-1:0]);
    w_spawn_st.vy.neg = spawn_vy[SPEED_W];
    w_spawn_st.vy.mag = MAG_MAX'(spawn_vy[SPEED_W-1:0]);
  end

`ifdef ROCK_SPLIT_EN
  slot_t                w_st [NUM_ROCKS];
  slot_t                w_parent_st;
  logic [NUM_ROCKS-1:0] w_large;
  logic [NUM_ROCKS-1:0] w_shrink;

  always_comb begin
    w_parent_st = '0;
    for (int i = 0; i < NUM_ROCKS; i++) begin
      w_large[i] = (w_st[i].size == LARGE);
      if (w_hit_sel[i]) w_parent_st = w_st[i];
    end
    w_shrink          = w_hit_sel & w_large;
    w_free            = w_hit_sel & ~w_large;
    w_child_vld       = (|w_shrink) && w_free_any;
    w_child_st        = w_parent_st;
    w_child_st.active = 1'b1;
    w_child_st.size   = SMALL;
    w_child_st.vy.neg = ~w_parent_st.vy.neg;
  end
`else
  always_comb begin
    w_free      = w_hit_sel;
    w_child_vld = 1'b0;
    w_child_st  = '0;
  end
`endif

  // Spawn and child creation are exclusive: spawn_ready is low whenever a hit is present.
  always_comb begin
    w_load_st = w_child_vld ? w_child_st : w_spawn_st;
    for (int i = 0; i < NUM_ROCKS; i++) begin
      w_load[i] = (w_spawn_fire || w_child_vld) && (w_free_idx == SW'(i));
      w_move[i] = frame_tick && !w_hit_sel[i];
    end
  end

  for (genvar g = 0; g < NUM_ROCKS; g++) begin : g_slot
    rock_slot #(
      .COORD_W  (COORD_W),
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H),
      .R_LARGE  (R_LARGE),
      .R_SMALL  (R_SMALL),
      .CUT      (CUT)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .i_load    (w_load[g]),
      .i_load_st (w_load_st),
      .i_free    (w_free[g]),
      .i_move    (w_move[g]),
`ifdef ROCK_SPLIT_EN
      .i_shrink  (w_shrink[g]),
      .o_st      (w_st[g]),
`endif
      .i_px      (px),
      .i_py      (py),
      .o_active  (active_mask[g]),
      .o_cover   (w_cover[g])
    );
  end

  always_comb begin
    w_pix_any = |w_cover;
    w_pix_idx = '0;
    for (int i = NUM_ROCKS - 1; i >= 0; i--) begin
      if (w_cover[i]) w_pix_idx = SW'(i);
    end
  end

  always_comb begin
    active_count = '0;
    for (int i = 0; i < NUM_ROCKS; i++) begin
      active_count = active_count + CW'(active_mask[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pixel      <= 1'b0;
      r_pixel_slot <= '0;
    end else begin
      r_pixel      <= w_pix_any;
      r_pixel_slot <= w_pix_idx;
    end
  end

  assign pixel      = r_pixel;
  assign pixel_slot = r_pixel_slot;
endmodule

// File: tb/tb_rock_field.sv
// Bench for rock_field: reference slot model, render scoreboard, handshake/occupancy checks.
module tb_rock_field;
  localparam int NR = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       spawn_valid;
  logic       spawn_ready;
  logic [9:0] spawn_x, spawn_y;
  logic [2:0] spawn_vx, spawn_vy;
  logic       hit_valid;
  logic [2:0] hit_slot;
  logic [9:0] px, py;
  logic       pixel;
  logic [2:0] pixel_slot;
  logic [7:0] active_mask;
  logic [3:0] active_count;

  rock_field dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .spawn_valid  (spawn_valid),
    .spawn_ready  (spawn_ready),
    .spawn_x      (spawn_x),
    .spawn_y      (spawn_y),
    .spawn_vx     (spawn_vx),
    .spawn_vy     (spawn_vy),
    .hit_valid    (hit_valid),
    .hit_slot     (hit_slot),
    .px           (px),
    .py           (py),
    .pixel        (pixel),
    .pixel_slot   (pixel_slot),
    .active_mask  (active_mask),
    .active_count (active_count)
  );

  always #5 clk = ~clk;

  int   n_run  = 0;
  int   n_fail = 0;
  int   q_pix[$];
  int   q_slot[$];
  logic probe_on = 1'b0;

  int m_act[NR], m_large[NR], m_x[NR], m_y[NR], m_vx[NR], m_vy[NR];

  task automatic check_eq(input string tag, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic int m_free();
    for (int i = 0; i < NR; i++) if (m_act[i] == 0) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NR; i++) c += m_act[i];
    return c;
  endfunction

  function automatic int m_mask();
    int m = 0;
    for (int i = 0; i < NR; i++) if (m_act[i] != 0) m |= (1 << i);
    return m;
  endfunction

  function automatic int wrapm(input int v, input int m);
    return ((v % m) + m) % m;
  endfunction

  function automatic bit m_cover(input int i, input int x, input int y);
    int r, dx, dy;
    if (m_act[i] == 0 || x >= 640 || y >= 480) return 1'b0;
    r  = (m_large[i] != 0) ? 12 : 6;
    dx = (x > m_x[i]) ? x - m_x[i] : m_x[i] - x;
    dy = (y > m_y[i]) ? y - m_y[i] : m_y[i] - y;
    return ((dx < r) && (dy < r - 2)) || ((dx < r - 2) && (dy < r));
  endfunction

  function automatic logic [2:0] enc_vel(input int v);
    int m;
    m = (v < 0) ? -v : v;
    return {v < 0, m[1:0]};
  endfunction

  task automatic m_step(input bit rst_i, input bit tick, input bit fire,
                        input int sx, input int sy, input int svx, input int svy,
                        input bit hv, input int hs);
    bit skip[NR];
    int f;
    if (rst_i) begin
      for (int i = 0; i < NR; i++) m_act[i] = 0;
      return;
    end
    for (int i = 0; i < NR; i++) skip[i] = 1'b0;
    if (hv && m_act[hs] != 0) begin
      skip[hs] = 1'b1;
`ifdef ROCK_SPLIT_EN
      if (m_large[hs] != 0) begin
        f = m_free();
        if (f >= 0) begin
          m_act[f] = 1; m_large[f] = 0; m_x[f] = m_x[hs]; m_y[f] = m_y[hs];
          m_vx[f] = m_vx[hs]; m_vy[f] = -m_vy[hs]; skip[f] = 1'b1;
        end
        m_large[hs] = 0;
        m_vx[hs] = -m_vx[hs];
      end else begin
        m_act[hs] = 0;
      end
`else
      m_act[hs] = 0;
`endif
    end
    if (tick) begin
      for (int i = 0; i < NR; i++) begin
        if (m_act[i] != 0 && !skip[i]) begin
          m_x[i] = wrapm(m_x[i] + m_vx[i], 640);
          m_y[i] = wrapm(m_y[i] + m_vy[i], 480);
        end
      end
    end
    if (fire) begin
      f = m_free();
      m_act[f] = 1; m_large[f] = 1;
      m_x[f] = (sx >= 640) ? 639 : sx;
      m_y[f] = (sy >= 480) ? 479 : sy;
      m_vx[f] = svx; m_vy[f] = svy;
    end
  endtask

  // One clock of stimulus, entered and left on the falling edge.
  task automatic cyc(input bit rst_i, input bit tick, input bit sv,
                     input int sx, input int sy, input int svx, input int svy,
                     input bit hv, input int hs, input bit pr, input int ppx, input int ppy);
    bit exp_rdy;
    int ep, es;
    reset = rst_i; frame_tick = tick; spawn_valid = sv;
    spawn_x = sx[9:0]; spawn_y = sy[9:0];
    spawn_vx = enc_vel(svx); spawn_vy = enc_vel(svy);
    hit_valid = hv; hit_slot = hs[2:0];
    px = ppx[9:0]; py = ppy[9:0]; probe_on = pr;
    #1;
    exp_rdy = (m_free() >= 0) && !hv;
    if (sv && !rst_i) check_eq("spawn_ready", int'(spawn_ready), int'(exp_rdy));
    if (pr) begin
      ep = 0; es = 0;
      if (!rst_i) begin
        for (int i = NR - 1; i >= 0; i--) if (m_cover(i, ppx, ppy)) begin ep = 1; es = i; end
      end
      q_pix.push_back(ep);
      q_slot.push_back(es);
    end
    m_step(rst_i, tick, sv && exp_rdy && !rst_i, sx, sy, svx, svy, hv, hs);
    @(negedge clk);
  endtask

  task automatic idle();                       cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_rst();                     cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic tick();                       cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic hit(input int s);             cyc(0, 0, 0, 0, 0, 0, 0, 1, s, 0, 0, 0); endtask
  task automatic probe(input int x, input int y); cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, x, y); endtask
  task automatic spawn(input int x, input int y, input int vx, input int vy);
    cyc(0, 0, 1, x, y, vx, vy, 0, 0, 0, 0, 0);
  endtask

  task automatic probe_edges(input int cx, input int cy, input int r);
    int xs[8], ys[8];
    xs = '{cx + r - 1, cx + r, cx - r + 1, cx - r, cx, cx, cx, cx};
    ys = '{cy, cy, cy, cy, cy + r - 1, cy + r, cy - r + 1, cy - r};
    probe(cx, cy);
    for (int k = 0; k < 8; k++) if (xs[k] >= 0 && xs[k] < 1024 && ys[k] >= 0 && ys[k] < 1024) probe(xs[k], ys[k]);
  endtask

  task automatic check_occupancy(input string tag);
    check_eq({tag, "_count"}, int'(active_count), m_count());
    check_eq({tag, "_mask"}, int'(active_mask), m_mask());
  endtask

  // Render scoreboard: a probe presented before edge N is due on the outputs just after edge N.
  initial begin
    logic launched;
    int   ep, es;
    forever begin
      @(posedge clk);
      launched = probe_on;
      #1;
      if (launched) begin
        if (q_pix.size() == 0) begin
          check_eq("sb_underflow", 1, 0);
        end else begin
          ep = q_pix.pop_front();
          es = q_slot.pop_front();
          check_eq("pixel", int'(pixel), ep);
          check_eq("pixel_slot", int'(pixel_slot), es);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nh;
    reset = 1'b1; frame_tick = 0; spawn_valid = 0; spawn_x = 0; spawn_y = 0;
    spawn_vx = 0; spawn_vy = 0; hit_valid = 0; hit_slot = 0; px = 0; py = 0;
    for (int i = 0; i < NR; i++) begin
      m_act[i] = 0; m_large[i] = 0; m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_vy[i] = 0;
    end
    @(negedge clk);
    do_rst(); do_rst(); idle();
    check_eq("rst_pixel", int'(pixel), 0);
    check_eq("rst_pixel_slot", int'(pixel_slot), 0);
    check_eq("rst_mask", int'(active_mask), 0);
    check_eq("rst_count", int'(active_count), 0);
    check_eq("rst_ready", int'(spawn_ready), 1);

    // Basic motion: slot0 ends at (103,194).
    spawn(100, 200, 1, -2);
    check_occupancy("spawn1");
    tick(); tick(); tick();
    probe_edges(103, 194, 12);

    // Wrap on both axes.
    spawn(639, 100, 3, 0);
    spawn(300, 1, 0, -2);
    tick();
    probe_edges(2, 100, 12);
    probe_edges(300, 479, 12);

    // Corner cut and lowest-index priority.
    spawn(320, 240, 0, 0);
    probe(331, 237); probe(331, 239); probe(331, 238); probe(331, 228);
    probe(330, 229); probe(329, 231);
    spawn(325, 240, 0, 0);
    probe(322, 240); probe(335, 240); probe(340, 240);

    // Fill the pool, including a clamped spawn.
    spawn(50, 400, 0, 0);
    spawn(600, 50, 0, 0);
    spawn(700, 500, 0, 0);
    check_occupancy("full");
    check_eq("full_ready", int'(spawn_ready), 0);
    probe_edges(639, 479, 12);

    // Held spawn while slot5 is hit; it lands once the slot frees.
`ifdef ROCK_SPLIT_EN
    nh = 2;
`else
    nh = 1;
`endif
    for (int k = 0; k < nh; k++) begin
      cyc(0, 0, 1, 500, 50, 0, 0, 1, 5, 0, 0, 0);
      check_occupancy("hit5");
    end
    spawn(500, 50, 0, 0);
    check_occupancy("refill");
    probe(500, 50);

    // Hit on a LARGE rock (split or free), then an ignored hit on an idle slot.
    do_rst(); idle();
    spawn(200, 200, 1, 2);
    hit(0);
    check_occupancy("split");
    hit(5);
    check_occupancy("hit_idle");
    tick();
    probe_edges(199, 202, 6);
    probe_edges(201, 198, 6);

    // Hit + spawn on a frame tick, then reset mid-frame.
    do_rst(); idle();
    spawn(100, 100, 1, 1);
    spawn(400, 300, -1, -1);
    cyc(0, 1, 1, 200, 200, 0, 0, 1, 0, 0, 0, 0);
    spawn(200, 200, 0, 0);
    check_occupancy("stall");
    probe_edges(399, 299, 12);
    probe_edges(100, 100, 6);
    probe(200, 200);
    cyc(1, 1, 1, 300, 300, 0, 0, 1, 1, 1, 399, 299);
    probe(399, 299);
    check_occupancy("midrst");
    check_eq("midrst_ready", int'(spawn_ready), 1);

    idle(); idle();
    check_eq("sb_drain", q_pix.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
